// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit and M->W pipeline register with a req/ready data bus.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        RegWriteM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic        misalign_err
);

    typedef enum logic {IDLE, BUSY} LsuState;

    LsuState     state, nextState;
    logic        memOp, misaligned;
    logic        startReq, finishReq, abortReq, bubble, errNext, timeoutHit;
    logic [3:0]  storeBe;
    logic [31:0] storeData, loadData;
    logic [1:0]  offQ, sizeQ;
    logic        signedQ;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign memOp      = MemReadM | MemWriteM;
    assign misaligned = ((MemSizeM == 2'b01) && ALUOutM[0]) ||
                        (MemSizeM[1] && (ALUOutM[1:0] != 2'b00));

    // Lane placement for the bus; loads reuse the same enables to mark the lanes they read.
    always_comb begin
        storeBe   = 4'b1111;
        storeData = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                storeBe   = 4'b0001 << ALUOutM[1:0];
                storeData = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                storeBe   = 4'b0011 << {ALUOutM[1], 1'b0};
                storeData = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byteSel  = mem_rdata[7:0];
        case (offQ)
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            2'd3:    byteSel = mem_rdata[31:24];
            default: byteSel = mem_rdata[7:0];
        endcase
        halfSel  = offQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        loadData = mem_rdata;
        case (sizeQ)
            2'b00:   loadData = signedQ ? {{24{byteSel[7]}}, byteSel} : {24'b0, byteSel};
            2'b01:   loadData = signedQ ? {{16{halfSel[15]}}, halfSel} : {16'b0, halfSel};
            default: loadData = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] waitCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            waitCnt <= 8'd0;
        else if (startReq)
            waitCnt <= 8'd0;
        else if (state == BUSY && !mem_ready)
            waitCnt <= waitCnt + 8'd1;
    end

    assign timeoutHit = (state == BUSY) && !mem_ready &&
                        (waitCnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    // While BUSY the W stage keeps receiving bubbles so nothing writes back twice.
    always_comb begin
        nextState = state;
        StallM    = 1'b0;
        startReq  = 1'b0;
        finishReq = 1'b0;
        abortReq  = 1'b0;
        bubble    = 1'b0;
        errNext   = 1'b0;
        case (state)
            IDLE: begin
                if (memOp && misaligned) begin
                    bubble  = 1'b1;
                    errNext = 1'b1;
                end else if (memOp) begin
                    StallM    = 1'b1;
                    startReq  = 1'b1;
                    bubble    = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    finishReq = 1'b1;
                    nextState = IDLE;
                end else if (timeoutHit) begin
                    abortReq  = 1'b1;
                    bubble    = 1'b1;
                    errNext   = 1'b1;
                    nextState = IDLE;
                end else begin
                    StallM = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_be       <= 4'd0;
            offQ         <= 2'd0;
            sizeQ        <= 2'd0;
            signedQ      <= 1'b0;
            misalign_err <= 1'b0;
            MemtoRegW    <= 1'b0;
            RegWriteW    <= 1'b0;
            WriteRegW    <= 5'd0;
            ReadDataW    <= 32'd0;
            ALUOutW      <= 32'd0;
        end else begin
            misalign_err <= errNext;
            if (startReq) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUOutM[31:2], 2'b00};
                mem_wdata <= storeData;
                mem_be    <= storeBe;
                offQ      <= ALUOutM[1:0];
                sizeQ     <= MemSizeM;
                signedQ   <= MemSignedM;
            end else if (finishReq || abortReq) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            WriteRegW <= WriteRegM;
            ALUOutW   <= ALUOutM;
            if (bubble) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                ReadDataW <= 32'd0;
            end else begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= MemtoRegM;
                ReadDataW <= (finishReq && !mem_we) ? loadData : 32'd0;
            end
        end
    end

endmodule
